// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD time type, range presets and ordering helper for the stopwatch.
package stopwatch_pkg;
  localparam logic [15:0] LOW_PRESET  = 16'h1020;
  localparam logic [15:0] HIGH_PRESET = 16'h4930;
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;
  // Digit-major packing makes plain unsigned compare match time order for valid BCD.
  function automatic logic bcd_time_lt(input bcd_time_t a, input bcd_time_t b);
    return a < b;
  endfunction
endpackage

// File: rtl/bcd_minute_incdec.sv
// bcd_minute_incdec: combinational two-digit BCD +/-1 with wrap flag (99->00 or 00->99).
module bcd_minute_incdec (
  input  logic       dec_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       wrap_o
);
  logic c;
  assign c       = dec_i ? (units_i == 4'd0) : (units_i == 4'd9);
  assign units_o = dec_i ? (c ? 4'd9 : units_i - 4'd1) : (c ? 4'd0 : units_i + 4'd1);
  assign tens_o  = !c ? tens_i :
                   dec_i ? (tens_i == 4'd0 ? 4'd9 : tens_i - 4'd1) :
                           (tens_i == 4'd9 ? 4'd0 : tens_i + 4'd1);
  assign wrap_o  = c & (dec_i ? (tens_i == 4'd0) : (tens_i == 4'd9));
endmodule

// File: rtl/stopwatch_minute_adjust.sv
// stopwatch_minute_adjust: minute add/subtract with range clamp, reset preset select and load strobe.
module stopwatch_minute_adjust #(
  parameter logic [15:0] LOW_PRESET  = stopwatch_pkg::LOW_PRESET,
  parameter logic [15:0] HIGH_PRESET = stopwatch_pkg::HIGH_PRESET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] time_in,
  input  logic        reset_req,
  input  logic        reverse,
  input  logic        add,
  input  logic        subtract,
  output logic        load,
  output logic [15:0] load_value,
  output logic        clamped,
  output logic        tens_enable
);
  import stopwatch_pkg::bcd_time_t;
  import stopwatch_pkg::bcd_time_lt;
  bcd_time_t t, adj;
  logic [3:0] tens_n, units_n;
  logic wrap, invalid, do_add, do_sub, add_clamp, sub_clamp;
  logic load_q, load_d, clamped_q, clamped_d;
  logic [15:0] value_q, value_d;
  assign t = bcd_time_t'(time_in);
  bcd_minute_incdec u_incdec (
    .dec_i   (subtract),
    .tens_i  (t.min_tens),
    .units_i (t.min_units),
    .tens_o  (tens_n),
    .units_o (units_n),
    .wrap_o  (wrap)
  );
  assign adj     = '{min_tens: tens_n, min_units: units_n, sec_tens: t.sec_tens, sec_units: t.sec_units};
  assign invalid = (t.min_tens > 4'd4) | (t.min_units > 4'd9) | (t.sec_tens > 4'd9) | (t.sec_units > 4'd9);
  assign do_add  = add & ~subtract;
  assign do_sub  = subtract & ~add;
  assign add_clamp = invalid | wrap | bcd_time_lt(bcd_time_t'(HIGH_PRESET), adj);
  assign sub_clamp = invalid | wrap | bcd_time_lt(adj, bcd_time_t'(LOW_PRESET));
  always_comb begin
    load_d    = reset_req | do_add | do_sub;
    value_d   = reset_req ? (reverse ? HIGH_PRESET : LOW_PRESET) :
                do_add    ? (add_clamp ? HIGH_PRESET : 16'(adj)) :
                do_sub    ? (sub_clamp ? LOW_PRESET : 16'(adj)) : value_q;
    clamped_d = reset_req ? 1'b0 : do_add ? add_clamp : do_sub ? sub_clamp : clamped_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q    <= 1'b0;
      value_q   <= 16'h0000;
      clamped_q <= 1'b0;
    end else begin
      load_q    <= load_d;
      value_q   <= value_d;
      clamped_q <= clamped_d;
    end
  end
  assign load        = load_q;
  assign load_value  = value_q;
  assign clamped     = clamped_q;
  assign tens_enable = reverse ? (t.min_units == 4'd0) : (t.min_units == 4'd9);
endmodule

// File: tb/tb_stopwatch_minute_adjust.sv
// tb_stopwatch_minute_adjust: directed self-checking bench with hand-computed expectations.
module tb_stopwatch_minute_adjust;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic reset_req = 1'b0, reverse = 1'b0, add = 1'b0, subtract = 1'b0;
  logic load, clamped, tens_enable;
  logic [15:0] load_value;
  int checks = 0;
  int failures = 0;

  stopwatch_minute_adjust dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .time_in     (time_in),
    .reset_req   (reset_req),
    .reverse     (reverse),
    .add         (add),
    .subtract    (subtract),
    .load        (load),
    .load_value  (load_value),
    .clamped     (clamped),
    .tens_enable (tens_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic r, input logic rv, input logic a, input logic s, input logic [15:0] t);
    @(negedge clk);
    reset_req = r; reverse = rv; add = a; subtract = s; time_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic l, input logic [15:0] v, input logic c);
    chk({tag, "_load"}, {15'd0, load}, {15'd0, l});
    chk({tag, "_value"}, load_value, v);
    chk({tag, "_clamped"}, {15'd0, clamped}, {15'd0, c});
  endtask

  initial begin
    #12;
    expect_out("reset", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 0, 0, 16'h2222); expect_out("preset_up", 1'b1, 16'h1020, 1'b0);
    apply(1, 1, 0, 0, 16'h2222); expect_out("preset_down", 1'b1, 16'h4930, 1'b0);
    apply(0, 0, 1, 0, 16'h2945); expect_out("add_carry", 1'b1, 16'h3045, 1'b0);
    apply(0, 0, 1, 0, 16'h4930); expect_out("add_over", 1'b1, 16'h4930, 1'b1);
    apply(0, 0, 0, 1, 16'h3005); expect_out("sub_borrow", 1'b1, 16'h2905, 1'b0);
    apply(0, 0, 0, 1, 16'h1025); expect_out("sub_under", 1'b1, 16'h1020, 1'b1);
    apply(0, 0, 1, 0, 16'h4830); expect_out("add_exact", 1'b1, 16'h4930, 1'b0);
    apply(0, 0, 1, 0, 16'h4831); expect_out("add_just_over", 1'b1, 16'h4930, 1'b1);
    apply(0, 0, 0, 1, 16'h1120); expect_out("sub_exact", 1'b1, 16'h1020, 1'b0);
    apply(0, 0, 1, 0, 16'h1059); expect_out("add_plain", 1'b1, 16'h1159, 1'b0);
    apply(1, 1, 1, 0, 16'h2000); expect_out("reset_prio", 1'b1, 16'h4930, 1'b0);
    apply(0, 0, 1, 1, 16'h2000); expect_out("conflict", 1'b0, 16'h4930, 1'b0);
    apply(0, 0, 0, 1, 16'h0000); expect_out("sub_wrap", 1'b1, 16'h1020, 1'b1);
    apply(0, 0, 0, 0, 16'h3333); expect_out("idle_hold", 1'b0, 16'h1020, 1'b1);
    apply(0, 0, 1, 0, 16'h1A00); expect_out("add_bad_digit", 1'b1, 16'h4930, 1'b1);
    apply(0, 0, 0, 1, 16'h5000); expect_out("sub_bad_tens", 1'b1, 16'h1020, 1'b1);
    apply(0, 0, 1, 0, 16'h2000); expect_out("add_multi1", 1'b1, 16'h2100, 1'b0);
    @(posedge clk); #1;
    expect_out("add_multi2", 1'b1, 16'h2100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    add = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("post_rst", 1'b0, 16'h0000, 1'b0);
    for (int rv = 0; rv < 2; rv++) begin
      for (int u = 0; u < 16; u++) begin
        reverse = rv[0];
        time_in = {4'h2, u[3:0], 8'h15};
        #1;
        chk($sformatf("tens_en_r%0d_u%0d", rv, u), {15'd0, tens_enable},
            {15'd0, (rv == 0) ? (u == 9) : (u == 0)});
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
